// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite response codes and address-alignment helper.
package axi4_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Number of byte-offset address bits below the register index.
    function automatic int addr_lsb(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/axi4_lite_regbank.sv
// Register array with byte-strobed writes, combinational read mux and
// one-cycle write pulses. Indices outside NUM_REGS are flagged as errors.
module axi4_lite_regbank
    import axi4_lite_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16,
    parameter int IDX_W      = 10
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_en,
    input  logic [IDX_W-1:0]               wr_idx,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    input  logic [DATA_WIDTH/8-1:0]        wr_strb,
    input  logic [IDX_W-1:0]               rd_idx,
    output logic [DATA_WIDTH-1:0]          rd_data,
    output logic                           wr_err,
    output logic                           rd_err,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]            reg_wr_pulse
);

    localparam int STRB_W = DATA_WIDTH / 8;
    // One extra bit so NUM_REGS == 2**IDX_W still compares correctly.
    localparam logic [IDX_W:0] LIMIT = (IDX_W + 1)'(NUM_REGS);

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;

    assign wr_err  = {1'b0, wr_idx} >= LIMIT;
    assign rd_err  = {1'b0, rd_idx} >= LIMIT;
    assign reg_out = regs;

    // Strobe-masked register update; out-of-range indices match no register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs         <= '0;
            reg_wr_pulse <= '0;
        end else begin
            reg_wr_pulse <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_en && wr_idx == IDX_W'(i)) begin
                    reg_wr_pulse[i] <= 1'b1;
                    for (int b = 0; b < STRB_W; b++) begin
                        if (wr_strb[b]) regs[i][b*8 +: 8] <= wr_data[b*8 +: 8];
                    end
                end
            end
        end
    end

    // Read mux; unmatched (out-of-range) indices read as zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == IDX_W'(i)) rd_data = regs[i];
        end
    end

endmodule

// File: rtl/axi4_lite_s_regs.sv
// AXI4-Lite slave front end: AW/W capture and B response, AR/R response,
// mapped onto axi4_lite_regbank.
module axi4_lite_s_regs
    import axi4_lite_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int NUM_REGS   = 16
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    input  logic [ADDR_WIDTH-1:0]          AWADDR,
    input  logic [2:0]                     AWPROT,
    input  logic                           AWVALID,
    output logic                           AWREADY,
    input  logic [DATA_WIDTH-1:0]          WDATA,
    input  logic [DATA_WIDTH/8-1:0]        WSTRB,
    input  logic                           WVALID,
    output logic                           WREADY,
    output logic [1:0]                     BRESP,
    output logic                           BVALID,
    input  logic                           BREADY,
    input  logic [ADDR_WIDTH-1:0]          ARADDR,
    input  logic [2:0]                     ARPROT,
    input  logic                           ARVALID,
    output logic                           ARREADY,
    output logic [DATA_WIDTH-1:0]          RDATA,
    output logic [1:0]                     RRESP,
    output logic                           RVALID,
    input  logic                           RREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]            reg_wr_pulse
);

    localparam int ADDR_LSB = addr_lsb(DATA_WIDTH);
    localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;
    localparam int STRB_W   = DATA_WIDTH / 8;

    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
        $error("axi4_lite_s_regs: DATA_WIDTH must be 32 or 64");
    end
    if (NUM_REGS < 1 || NUM_REGS > (1 << IDX_W)) begin : g_bad_regs
        $error("axi4_lite_s_regs: NUM_REGS out of range for ADDR_WIDTH");
    end

    logic                   aw_held, w_held;
    logic [IDX_W-1:0]       aw_idx_q;
    logic [DATA_WIDTH-1:0]  w_data_q;
    logic [STRB_W-1:0]      w_strb_q;
    logic                   aw_hs, w_hs, ar_hs, commit;
    logic [IDX_W-1:0]       wr_idx, rd_idx;
    logic [DATA_WIDTH-1:0]  wr_data, rd_data;
    logic [STRB_W-1:0]      wr_strb;
    logic                   wr_err, rd_err;

    // Protection and byte-offset bits carry no meaning for a word register bank.
    logic unused_bits;
    assign unused_bits = ^{AWPROT, ARPROT, AWADDR[ADDR_LSB-1:0], ARADDR[ADDR_LSB-1:0]};

    assign AWREADY = !ARESET && !aw_held && !BVALID;
    assign WREADY  = !ARESET && !w_held  && !BVALID;
    assign ARREADY = !ARESET && !RVALID;

    assign aw_hs = AWVALID && AWREADY;
    assign w_hs  = WVALID  && WREADY;
    assign ar_hs = ARVALID && ARREADY;

    // Commit as soon as both halves are available, held or arriving this cycle,
    // so a same-cycle AW+W commits on the very next edge.
    assign commit  = (aw_held || aw_hs) && (w_held || w_hs);
    assign wr_idx  = aw_held ? aw_idx_q : AWADDR[ADDR_WIDTH-1:ADDR_LSB];
    assign wr_data = w_held  ? w_data_q : WDATA;
    assign wr_strb = w_held  ? w_strb_q : WSTRB;
    assign rd_idx  = ARADDR[ADDR_WIDTH-1:ADDR_LSB];

    // Hold whichever of AW/W arrives first until its partner shows up.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_idx_q <= '0;
            w_data_q <= '0;
            w_strb_q <= '0;
        end else if (commit) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
        end else begin
            if (aw_hs) begin
                aw_held  <= 1'b1;
                aw_idx_q <= AWADDR[ADDR_WIDTH-1:ADDR_LSB];
            end
            if (w_hs) begin
                w_held   <= 1'b1;
                w_data_q <= WDATA;
                w_strb_q <= WSTRB;
            end
        end
    end

    // Write response: raised at commit, held until accepted.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            BVALID <= 1'b0;
            BRESP  <= RESP_OKAY;
        end else if (commit) begin
            BVALID <= 1'b1;
            BRESP  <= wr_err ? RESP_SLVERR : RESP_OKAY;
        end else if (BVALID && BREADY) begin
            BVALID <= 1'b0;
        end
    end

    // Read response: registered from the pre-write contents, held until accepted.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            RVALID <= 1'b0;
            RDATA  <= '0;
            RRESP  <= RESP_OKAY;
        end else if (ar_hs) begin
            RVALID <= 1'b1;
            RDATA  <= rd_data;
            RRESP  <= rd_err ? RESP_SLVERR : RESP_OKAY;
        end else if (RVALID && RREADY) begin
            RVALID <= 1'b0;
        end
    end

    axi4_lite_regbank #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .IDX_W      (IDX_W)
    ) u_regbank (
        .clk          (ACLK),
        .rst          (ARESET),
        .wr_en        (commit),
        .wr_idx       (wr_idx),
        .wr_data      (wr_data),
        .wr_strb      (wr_strb),
        .rd_idx       (rd_idx),
        .rd_data      (rd_data),
        .wr_err       (wr_err),
        .rd_err       (rd_err),
        .reg_out      (reg_out),
        .reg_wr_pulse (reg_wr_pulse)
    );

endmodule

// File: tb/tb_axi4_lite_s_regs.sv
// Scoreboard bench for axi4_lite_s_regs (32-bit data, 16 registers).
module tb_axi4_lite_s_regs;

    logic         ACLK = 1'b0;
    logic         ARESET = 1'b0;
    logic [11:0]  AWADDR = '0;
    logic [2:0]   AWPROT = '0;
    logic         AWVALID = 1'b0;
    logic         AWREADY;
    logic [31:0]  WDATA = '0;
    logic [3:0]   WSTRB = '0;
    logic         WVALID = 1'b0;
    logic         WREADY;
    logic [1:0]   BRESP;
    logic         BVALID;
    logic         BREADY = 1'b0;
    logic [11:0]  ARADDR = '0;
    logic [2:0]   ARPROT = '0;
    logic         ARVALID = 1'b0;
    logic         ARREADY;
    logic [31:0]  RDATA;
    logic [1:0]   RRESP;
    logic         RVALID;
    logic         RREADY = 1'b0;
    logic [511:0] reg_out;
    logic [15:0]  reg_wr_pulse;

    int n_chk = 0;
    int n_err = 0;

    logic [1:0]  exp_b[$];
    logic [33:0] exp_r[$];

    axi4_lite_s_regs #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .NUM_REGS(16)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .reg_out(reg_out), .reg_wr_pulse(reg_wr_pulse)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] reg_word(input int i);
        return reg_out[i*32 +: 32];
    endfunction

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // Scoreboard: pop and compare on every completed B or R handshake.
    always @(negedge ACLK) begin
        logic [33:0] e;
        if (!ARESET && BVALID && BREADY) begin
            if (exp_b.size() == 0) chk("b_unexpected", 1, 0);
            else chk("bresp", BRESP, exp_b.pop_front());
        end
        if (!ARESET && RVALID && RREADY) begin
            if (exp_r.size() == 0) chk("r_unexpected", 1, 0);
            else begin
                e = exp_r.pop_front();
                chk("rdata", RDATA, e[31:0]);
                chk("rresp", RRESP, e[33:32]);
            end
        end
    end

    // Drive AW and W with independent start lags; returns just after the commit edge.
    task automatic axi_write(input logic [11:0] addr, input logic [31:0] d, input logic [3:0] s,
                             input int aw_lag, input int w_lag, input logic [1:0] r);
        bit aw_done, w_done, aw_f, w_f;
        int cyc;
        aw_done = 0; w_done = 0; cyc = 0;
        exp_b.push_back(r);
        AWADDR = addr; WDATA = d; WSTRB = s;
        while (!(aw_done && w_done) && cyc < 20) begin
            AWVALID = !aw_done && cyc >= aw_lag;
            WVALID  = !w_done  && cyc >= w_lag;
            @(negedge ACLK);
            aw_f = AWVALID && AWREADY;
            w_f  = WVALID && WREADY;
            tick();
            aw_done |= aw_f;
            w_done  |= w_f;
            cyc++;
        end
        AWVALID = 0; WVALID = 0;
        if (!(aw_done && w_done)) chk("wr_timeout", 0, 1);
    endtask

    task automatic wait_b();
        bit f;
        int cyc;
        f = 0; cyc = 0;
        BREADY = 1;
        while (!f && cyc < 20) begin
            @(negedge ACLK);
            f = BVALID;
            tick();
            cyc++;
        end
        BREADY = 0;
        if (!f) chk("b_timeout", 0, 1);
    endtask

    // Issue AR, hold RREADY low for lag cycles checking stability, then accept R.
    task automatic axi_read(input logic [11:0] addr, input logic [31:0] d, input logic [1:0] r,
                            input int lag);
        bit f;
        int cyc;
        f = 0; cyc = 0;
        exp_r.push_back({r, d});
        ARADDR = addr; ARVALID = 1;
        while (!f && cyc < 20) begin
            @(negedge ACLK);
            f = ARREADY;
            tick();
            cyc++;
        end
        ARVALID = 0;
        if (!f) chk("ar_timeout", 0, 1);
        for (int i = 0; i < lag; i++) begin
            chk("r_hold_valid", RVALID, 1);
            chk("r_hold_data", RDATA, d);
            chk("r_hold_arready", ARREADY, 0);
            tick();
        end
        RREADY = 1; f = 0; cyc = 0;
        while (!f && cyc < 20) begin
            @(negedge ACLK);
            f = RVALID;
            tick();
            cyc++;
        end
        RREADY = 0;
        if (!f) chk("r_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 ARESET = 1;
        #2;
        chk("rst_bvalid", BVALID, 0);
        chk("rst_rvalid", RVALID, 0);
        chk("rst_bresp", BRESP, 0);
        chk("rst_rresp", RRESP, 0);
        chk("rst_rdata", RDATA, 0);
        chk("rst_pulse", reg_wr_pulse, 0);
        chk("rst_ready", {AWREADY, WREADY, ARREADY}, 0);
        chk("rst_regs", (reg_out == '0), 1);
        repeat (2) @(posedge ACLK);
        #1 ARESET = 0;
        #1;
        chk("idle_ready", {AWREADY, WREADY, ARREADY}, 3'b111);

        // Same-cycle AW+W.
        axi_write(12'h008, 32'hDEADBEEF, 4'hF, 0, 0, 2'b00);
        chk("t1_bvalid", BVALID, 1);
        chk("t1_pulse", reg_wr_pulse, 16'h0004);
        chk("t1_reg2", reg_word(2), 32'hDEADBEEF);
        tick();
        chk("t1_pulse_off", reg_wr_pulse, 0);
        chk("t1_bvalid_hold", BVALID, 1);
        chk("t1_awready_blk", {AWREADY, WREADY}, 0);
        wait_b();

        // W first, AW three cycles later, single byte lane.
        axi_write(12'h008, 32'h000000AA, 4'h1, 3, 0, 2'b00);
        chk("t2_pulse", reg_wr_pulse, 16'h0004);
        chk("t2_reg2", reg_word(2), 32'hDEADBEAA);
        wait_b();

        // AW first, W two cycles later.
        axi_write(12'h004, 32'h11223344, 4'hF, 0, 2, 2'b00);
        chk("aw_first_reg1", reg_word(1), 32'h11223344);
        wait_b();

        // Sparse strobes.
        axi_write(12'h014, 32'hFFFFFFFF, 4'b1010, 0, 0, 2'b00);
        chk("strb_reg5", reg_word(5), 32'hFF00FF00);
        wait_b();

        // Read held with RREADY low; low address bits ignored; untouched register.
        axi_read(12'h008, 32'hDEADBEAA, 2'b00, 5);
        axi_read(12'h00B, 32'hDEADBEAA, 2'b00, 0);
        axi_read(12'h000, 32'h00000000, 2'b00, 0);

        // Out of range.
        axi_write(12'h040, 32'hCAFEF00D, 4'hF, 0, 0, 2'b10);
        chk("oor_pulse", reg_wr_pulse, 0);
        wait_b();
        axi_read(12'h040, 32'h00000000, 2'b10, 0);

        // Same-cycle read and write to one register.
        fork
            axi_write(12'h00C, 32'h12345678, 4'hF, 0, 0, 2'b00);
            axi_read(12'h00C, 32'h00000000, 2'b00, 0);
        join
        wait_b();
        axi_read(12'h00C, 32'h12345678, 2'b00, 0);

        // Reset while B waits for BREADY.
        axi_write(12'h010, 32'h00000055, 4'hF, 0, 0, 2'b00);
        chk("t6_bvalid", BVALID, 1);
        #2 ARESET = 1;
        #1;
        chk("t6_bvalid_clr", BVALID, 0);
        chk("t6_regs", (reg_out == '0), 1);
        chk("t6_ready", {AWREADY, WREADY, ARREADY}, 0);
        tick();
        chk("t6_ready_hold", {AWREADY, WREADY, ARREADY}, 0);
        exp_b.delete();
        ARESET = 0;
        #1;
        chk("t6_ready_back", {AWREADY, WREADY, ARREADY}, 3'b111);
        axi_read(12'h008, 32'h00000000, 2'b00, 0);

        chk("sb_empty", exp_b.size() + exp_r.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
